lut_decoder_driver: RTL
=======================

Name: lut_decoder_driver

Overview:
- Synthesizable stimulus transmitter for the lut_decoder verification environment.
- Sweeps every legal input combination (mode, format, iteration n, BKM digits d_x_n/d_y_n) and presents each as one vector on a valid/ready interface.
- Feeds the DUT and the reference model together. The checker consumes the results downstream.
- Also usable as an on-chip BIST source for the BKM LUT path.

Parameters:
- LOG2N, 6, width of iteration index n.
- N_MIN, 0, first iteration index swept.
- N_MAX, 63, last iteration index swept (N_MIN <= N_MAX < 2**LOG2N).
- NFMT, 4, number of format codes swept (0..NFMT-1, NFMT <= 4).
- WCNT, 16, width of vector counter.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- srst  in  1  synchronous reset, active high.
- enable  in  1  allows new vectors to be issued.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- drv_ready  in  1  consumer accepts the current vector.
- drv_valid  out  1  vector on drv_* is valid.
- drv_mode  out  1  mode bit.
- drv_format  out  2  format code.
- drv_n  out  LOG2N  iteration index.
- drv_d_x_n  out  2  signed digit for x.
- drv_d_y_n  out  2  signed digit for y.
- drv_last  out  1  marks the final vector of the sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last vector is accepted.
- vec_count  out  WCNT  number of vectors accepted since start.

Behaviour:
- Reset (arst_n=0 asynchronously, or srst=1 at a clock edge), srst has priority over everything else:
  - FSM goes to IDLE.
  - All outputs are 0, and all drv_* fields are 0.
- Digit encoding (2-bit signed): 2'b11=-1, 2'b00=0, 2'b01=+1. Sweep order within a digit is -1, 0, +1.
- Sweep order, innermost to outermost: d_y_n, d_x_n, n (N_MIN..N_MAX), format (0..NFMT-1), mode (0,1).
  - Total vectors = 2*NFMT*(N_MAX-N_MIN+1)*9. With the defaults this is 4608.
  - The vector count saturates at 2**WCNT-1.
- FSM states:
  - IDLE: start=1 clears counters, loads the first vector and goes to RUN. busy=1 from the next cycle.
  - RUN: drv_valid=1 when enable=1. All outputs are registered.
    - On drv_valid&&drv_ready: vec_count++. If drv_last, go to DONE; otherwise advance the counters.
  - DONE: done=1, busy=0, drv_valid=0 for exactly one cycle, then back to IDLE.
- Latency: start at cycle t gives drv_valid=1 at t+1 with mode=0, format=0, n=N_MIN, d_x=11, d_y=11. Assumes enable=1.
- Handshake rules:
  - Once drv_valid=1, it and all drv_* fields stay stable until drv_ready=1.
  - enable=0 never drops a pending valid. It only stops the next vector being presented after a transfer: drv_valid=0 until enable returns.
  - Back-to-back transfers run at one vector per cycle when drv_ready is held at 1.
- drv_last=1 only on the final vector: mode=1, format=NFMT-1, n=N_MAX, d_x=01, d_y=01.
- start is ignored while busy=1 or in DONE.
- Wrap-around: a counter at its maximum resets to its minimum and carries into the next counter outward. The carry out of mode is only ever reached through drv_last.
- srst mid-sweep aborts immediately: drv_valid drops the next cycle and no done pulse is produced.

Optional Feature:
- Macro: LUT_DRV_ILLEGAL_DIGIT_EN.
- Defined:
  - The digit sweep also includes the reserved code 2'b10 as a fourth value, so the order is 11, 00, 01, 10. This exercises the decoder's illegal-digit handling.
  - Total vectors = 2*NFMT*(N_MAX-N_MIN+1)*16.
  - drv_last falls on d_x=d_y=10.
- Undefined: only the three legal codes are swept, as above.

Decomposition:
- Package lut_decoder_pkg holds:
  - digit code constants DIGIT_NEG, DIGIT_ZERO, DIGIT_POS, DIGIT_RSV;
  - the FSM state encoding (IDLE, RUN, DONE);
  - a function returning the total vector count for the given parameters.
- Sub-module lut_digit_cnt: one-digit counter stepping through the code sequence.
  - Inputs: inc.
  - Outputs: code, wrap.
  - Instantiated twice (d_y, d_x); the n, format and mode counters stay inline.

Test Plan:
- Reset release, start pulse, drv_ready=1 (defaults): first vector at t+1 is {0,0,0,11,11}. Exactly 4608 transfers follow, drv_last only on the last one, done pulses once, vec_count=4608.
- N_MIN=N_MAX=5, NFMT=1, drv_ready toggled randomly: 18 vectors in order. Fields stay stable while valid&&!ready, and n is always 5.
- enable dropped while valid=1 and ready=0: valid stays high until accepted, then goes low. Issuing resumes one cycle after enable returns to 1, with no vector lost or repeated.
- srst asserted after 100 transfers: next cycle valid=0 and busy=0 with no done pulse. A new start restarts from the first vector with vec_count=0.
- arst_n pulsed asynchronously mid-cycle during RUN: all outputs go to 0 immediately. start pulsed while busy is ignored.
- LUT_DRV_ILLEGAL_DIGIT_EN defined, defaults: 8192 vectors. The d_y sequence is 11, 00, 01, 10, and drv_last falls on d_x=d_y=10.

Source files
------------

// File: rtl/lut_decoder_pkg.sv
// Shared constants, FSM encoding and sizing helper for the lut_decoder stimulus driver.
// LUT_DRV_ILLEGAL_DIGIT_EN adds the reserved digit code 2'b10 to the sweep.
package lut_decoder_pkg;

  localparam logic [1:0] DIGIT_NEG  = 2'b11;
  localparam logic [1:0] DIGIT_ZERO = 2'b00;
  localparam logic [1:0] DIGIT_POS  = 2'b01;
  localparam logic [1:0] DIGIT_RSV  = 2'b10;

`ifdef LUT_DRV_ILLEGAL_DIGIT_EN
  localparam logic [1:0]  DIGIT_LAST   = DIGIT_RSV;
  localparam int unsigned DIGIT_VALUES = 4;
`else
  localparam logic [1:0]  DIGIT_LAST   = DIGIT_POS;
  localparam int unsigned DIGIT_VALUES = 3;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } drv_state_e;

  function automatic int unsigned total_vectors(int unsigned nfmt, int unsigned n_min,
                                                int unsigned n_max);
    return 2 * nfmt * (n_max - n_min + 1) * DIGIT_VALUES * DIGIT_VALUES;
  endfunction

endpackage

// File: rtl/lut_digit_cnt.sv
// One BKM digit counter stepping 11, 00, 01 (, 10) and flagging its last code.
// LUT_DRV_ILLEGAL_DIGIT_EN (via the package) selects whether 10 is included.
module lut_digit_cnt
  import lut_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       srst,
  input  logic       clr,
  input  logic       inc,
  output logic [1:0] code,
  output logic       wrap
);

  assign wrap = (code == DIGIT_LAST);

  // The code order 11, 00, 01, 10 is plain binary increment modulo 4.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      code <= '0;
    end else if (srst) begin
      code <= '0;
    end else if (clr) begin
      code <= DIGIT_NEG;
    end else if (inc) begin
      code <= wrap ? DIGIT_NEG : code + 2'd1;
    end
  end

endmodule

// File: rtl/lut_decoder_driver.sv
// Valid/ready stimulus source sweeping mode, format, n and both BKM digits for lut_decoder.
// Define LUT_DRV_ILLEGAL_DIGIT_EN to include the reserved digit code in the sweep.
module lut_decoder_driver
  import lut_decoder_pkg::*;
#(
  parameter int unsigned LOG2N = 6,
  parameter int unsigned N_MIN = 0,
  parameter int unsigned N_MAX = 63,
  parameter int unsigned NFMT  = 4,
  parameter int unsigned WCNT  = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             drv_ready,
  output logic             drv_valid,
  output logic             drv_mode,
  output logic [1:0]       drv_format,
  output logic [LOG2N-1:0] drv_n,
  output logic [1:0]       drv_d_x_n,
  output logic [1:0]       drv_d_y_n,
  output logic             drv_last,
  output logic             busy,
  output logic             done,
  output logic [WCNT-1:0]  vec_count
);

  localparam logic [LOG2N-1:0] N_FIRST = LOG2N'(N_MIN);
  localparam logic [LOG2N-1:0] N_FINAL = LOG2N'(N_MAX);
  localparam logic [1:0]       FMT_FINAL = 2'(NFMT - 1);

  drv_state_e state, state_nxt;
  logic       valid_nxt, busy_nxt, done_nxt;
  logic       load, adv, xfer;
  logic       dy_wrap, dx_wrap;

  assign xfer = drv_valid && drv_ready;

  always_comb begin
    state_nxt = state;
    valid_nxt = drv_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          valid_nxt = enable;
          busy_nxt  = 1'b1;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          if (drv_last) begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            adv       = 1'b1;
            valid_nxt = enable;
          end
        end else if (!drv_valid) begin
          // A pending vector is never withdrawn; enable only gates presenting a new one.
          valid_nxt = enable;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      drv_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (srst) begin
      state     <= IDLE;
      drv_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      drv_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  lut_digit_cnt u_dy (
    .clk    (clk),
    .arst_n (arst_n),
    .srst   (srst),
    .clr    (load),
    .inc    (adv),
    .code   (drv_d_y_n),
    .wrap   (dy_wrap)
  );

  lut_digit_cnt u_dx (
    .clk    (clk),
    .arst_n (arst_n),
    .srst   (srst),
    .clr    (load),
    .inc    (adv && dy_wrap),
    .code   (drv_d_x_n),
    .wrap   (dx_wrap)
  );

  // Mode only ever toggles 0 -> 1 here; its own wrap is handled by drv_last ending the sweep.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      drv_mode   <= 1'b0;
      drv_format <= '0;
      drv_n      <= '0;
    end else if (srst) begin
      drv_mode   <= 1'b0;
      drv_format <= '0;
      drv_n      <= '0;
    end else if (load) begin
      drv_mode   <= 1'b0;
      drv_format <= '0;
      drv_n      <= N_FIRST;
    end else if (adv && dy_wrap && dx_wrap) begin
      if (drv_n == N_FINAL) begin
        drv_n <= N_FIRST;
        if (drv_format == FMT_FINAL) begin
          drv_format <= '0;
          drv_mode   <= ~drv_mode;
        end else begin
          drv_format <= drv_format + 2'd1;
        end
      end else begin
        drv_n <= drv_n + LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vec_count <= '0;
    end else if (srst) begin
      vec_count <= '0;
    end else if (load) begin
      vec_count <= '0;
    end else if (xfer && (vec_count != '1)) begin
      vec_count <= vec_count + WCNT'(1);
    end
  end

  assign drv_last = drv_mode && (drv_format == FMT_FINAL) && (drv_n == N_FINAL)
                    && dx_wrap && dy_wrap;

endmodule
